// File: rtl/multdiv_unit.sv
// Sequential signed 32-bit multiply/divide unit.
// Both operations run 32 radix-2 iterations on operand magnitudes and fix
// the sign up on the final edge, so one pair of shift registers serves both.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    // Multiply: acc_hi_q = running partial product, acc_lo_q = multiplier/low product.
    // Divide:   acc_hi_q = partial remainder,       acc_lo_q = dividend/quotient.
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] opnd_q;    // multiplicand or divisor magnitude
    logic        neg_q;     // result must be negated
    logic        dzero_q;   // divisor was zero

    logic [31:0] a_abs;
    logic [31:0] b_abs;

    logic [32:0] mult_sum;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [63:0] mult_mag;
    logic [31:0] mult_res;
    logic        mult_ovf;

    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] div_res;
    logic        div_exc;

    // Operand magnitudes for latching at a start edge.
    always_comb begin
        a_abs = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        b_abs = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    end

    // One shift-add multiply step and the signed result of the final step.
    always_comb begin
        mult_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : 32'd0)};
        mult_hi  = mult_sum[32:1];
        mult_lo  = {mult_sum[0], acc_lo_q[31:1]};
        mult_mag = {mult_hi, mult_lo};
        mult_res = neg_q ? (~mult_lo + 32'd1) : mult_lo;
        // A negative result may reach magnitude 2^31; a positive one only 2^31-1.
        mult_ovf = neg_q ? (mult_mag > 64'h0000_0000_8000_0000)
                         : (mult_mag > 64'h0000_0000_7FFF_FFFF);
    end

    // One restoring-division step and the signed quotient of the final step.
    always_comb begin
        div_sh  = {acc_hi_q, acc_lo_q[31]};
        div_ge  = (div_sh >= {1'b0, opnd_q});
        div_hi  = div_ge ? (div_sh[31:0] - opnd_q) : div_sh[31:0];
        div_lo  = {acc_lo_q[30:0], div_ge};
        div_res = dzero_q ? 32'd0 : (neg_q ? (~div_lo + 32'd1) : div_lo);
        // Only 0x80000000 / -1 yields a positive quotient of 2^31.
        div_exc = dzero_q | (~neg_q & div_lo[31]);
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= 5'd0;
            acc_hi_q       <= 32'd0;
            acc_lo_q       <= 32'd0;
            opnd_q         <= 32'd0;
            neg_q          <= 1'b0;
            dzero_q        <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (ctrl_MULT) begin
                        state_q  <= StMult;
                        cnt_q    <= 5'd0;
                        acc_hi_q <= 32'd0;
                        acc_lo_q <= b_abs;
                        opnd_q   <= a_abs;
                        neg_q    <= data_operandA[31] ^ data_operandB[31];
                        dzero_q  <= 1'b0;
                        busy     <= 1'b1;
                    end else if (ctrl_DIV) begin
                        state_q  <= StDiv;
                        cnt_q    <= 5'd0;
                        acc_hi_q <= 32'd0;
                        acc_lo_q <= a_abs;
                        opnd_q   <= b_abs;
                        neg_q    <= data_operandA[31] ^ data_operandB[31];
                        dzero_q  <= (data_operandB == 32'd0);
                        busy     <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StMult: begin
                    acc_hi_q <= mult_hi;
                    acc_lo_q <= mult_lo;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q        <= StDone;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= mult_res;
                        data_exception <= mult_ovf;
                    end
                end
                StDiv: begin
                    acc_hi_q <= div_hi;
                    acc_lo_q <= div_lo;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q        <= StDone;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= div_res;
                        data_exception <= div_exc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus a chain of
// random back-to-back operations checked against an arithmetic reference model.
module tb_multdiv_unit;

    localparam longint IntMax = 64'sh0000_0000_7FFF_FFFF;
    localparam longint IntMin = -64'sh0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference behaviour from plain signed arithmetic.
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > IntMax) || (p < IntMin);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       rand_opnd = 32'd0;
            1:       rand_opnd = 32'hFFFF_FFFF;
            2:       rand_opnd = 32'h8000_0000;
            3:       rand_opnd = 32'($urandom_range(0, 40)) - 32'd20;
            4:       rand_opnd = 32'($urandom_range(0, 65535));
            default: rand_opnd = $urandom;
        endcase
    endfunction

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
    endtask

    // Let the start edge happen, then follow all 32 iterations. A stray start
    // pulse is raised so that edge intr+1 samples it (intr < 0: none).
    task automatic finish_op(input string tag, input bit is_mult, input logic [31:0] a,
                             input logic [31:0] b, input int intr,
                             output logic [31:0] exp_r, output logic exp_e);
        model(is_mult, a, b, exp_r, exp_e);
        tick();
        for (int i = 0; i < 32; i++) begin
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = (i == intr);
            data_operandA = $urandom;
            data_operandB = $urandom;
            check_eq({tag, " busy/rdy in flight"}, {busy, data_resultRDY}, 2'b10);
            tick();
        end
        ctrl_DIV = 1'b0;
        check_eq({tag, " busy/rdy at done"}, {busy, data_resultRDY}, 2'b01);
        check_eq({tag, " result"}, data_result, exp_r);
        check_eq({tag, " exception"}, data_exception, exp_e);
    endtask

    task automatic hold_check(input string tag, input logic [31:0] r, input logic e);
        tick();
        check_eq({tag, " busy/rdy after done"}, {busy, data_resultRDY}, 2'b00);
        check_eq({tag, " held result"}, data_result, r);
        check_eq({tag, " held exception"}, data_exception, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [31:0] a;
        logic [31:0] b;
        bit          m;
        int          intr;

        // Reset with a start pulse on the same edges: pulse must be discarded.
        reset = 1'b1;
        start_op(1'b1, 1'b0, 32'd7, 32'd3);
        tick();
        tick();
        check_eq("reset outputs", {data_result, data_exception, data_resultRDY, busy}, 35'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        tick();
        check_eq("idle after reset", {busy, data_resultRDY}, 2'b00);

        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        finish_op("mul 7*-3", 1'b1, 32'd7, 32'hFFFF_FFFD, -1, er, ee);
        check_eq("mul 7*-3 literal", data_result, 32'hFFFF_FFEB);
        hold_check("mul 7*-3", er, ee);

        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        finish_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, -1, er, ee);
        check_eq("mul ovf literal", {data_exception, data_result}, 33'h1_0000_0000);
        hold_check("mul ovf", er, ee);

        start_op(1'b0, 1'b1, 32'hFFFF_FFEB, 32'd4);
        finish_op("div -21/4", 1'b0, 32'hFFFF_FFEB, 32'd4, -1, er, ee);
        check_eq("div -21/4 literal", data_result, 32'hFFFF_FFFB);
        hold_check("div -21/4", er, ee);

        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        finish_op("div by zero", 1'b0, 32'd5, 32'd0, -1, er, ee);
        hold_check("div by zero", er, ee);

        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, er, ee);
        check_eq("div min/-1 literal", {data_exception, data_result}, 33'h1_8000_0000);
        hold_check("div min/-1", er, ee);

        // Both start pulses high: multiply wins.
        start_op(1'b1, 1'b1, 32'd6, 32'd7);
        finish_op("mult priority", 1'b1, 32'd6, 32'd7, -1, er, ee);
        hold_check("mult priority", er, ee);

        // Stray divide pulse sampled at E10 is ignored; exactly one ready pulse.
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        finish_op("ignore start", 1'b1, 32'd3, 32'd5, 9, er, ee);
        check_eq("ignore start literal", data_result, 32'd15);
        for (int i = 0; i < 3; i++) hold_check("ignore start", er, ee);

        // Reset at E15 aborts a divide; multiply started at E20 completes after E52.
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        tick();
        ctrl_DIV = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check_eq("abort busy before reset", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort outputs", {data_result, data_exception, data_resultRDY, busy}, 35'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("abort no ready", {busy, data_resultRDY}, 2'b00);
        end
        start_op(1'b1, 1'b0, 32'd2, 32'd2);
        finish_op("after abort", 1'b1, 32'd2, 32'd2, -1, er, ee);
        check_eq("after abort literal", data_result, 32'd4);

        // Random back-to-back chain: every new start is raised in the DONE cycle.
        for (int k = 0; k < 40; k++) begin
            m    = 1'($urandom_range(0, 1));
            a    = rand_opnd();
            b    = rand_opnd();
            intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            start_op(m, ~m, a, b);
            finish_op(m ? "rand mul" : "rand div", m, a, b, intr, er, ee);
        end
        hold_check("rand tail", er, ee);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL have no parameters; the operand and result width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ctrl_MULT, input, 1 bit: a one-cycle pulse that starts a signed multiply.
REQ-005 The block SHALL have port ctrl_DIV, input, 1 bit: a one-cycle pulse that starts a signed divide.
REQ-006 The block SHALL have port data_operandA, input, 32 bits: the multiplicand or dividend, sampled at the start edge only.
REQ-007 The block SHALL have port data_operandB, input, 32 bits: the multiplier or divisor, sampled at the start edge only.
REQ-008 The block SHALL have port data_result, output, 32 bits: the product (low 32 bits) or the quotient.
REQ-009 The block SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero, valid while data_resultRDY is high and held until the next start.
REQ-010 The block SHALL have port data_resultRDY, output, 1 bit: a one-cycle result-valid pulse.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in flight, so that execute can stall fetch and decode.

Function
REQ-012 The block SHALL implement four states: IDLE, MULT, DIV and DONE.
REQ-013 In IDLE, an edge with ctrl_MULT=1 SHALL latch both operands, clear the iteration counter and go to MULT.
REQ-014 In IDLE, an edge with ctrl_DIV=1 and ctrl_MULT=0 SHALL latch both operands, clear the iteration counter and go to DIV.
REQ-015 If ctrl_MULT and ctrl_DIV are both high at a start edge, ctrl_MULT SHALL win.
REQ-016 In MULT and DIV, each edge SHALL perform one radix-2 iteration and increment a 5-bit counter.
REQ-017 The edge that completes the 32nd iteration (counter=31) SHALL move the FSM to DONE.
REQ-018 DONE SHALL last exactly one cycle: data_resultRDY=1 and busy=0 during DONE, and the next edge SHALL go to IDLE.
REQ-019 A start pulse that arrives during DONE SHALL be accepted exactly as it would be in IDLE.
REQ-020 Latency: if the start is sampled at edge E0, data_resultRDY SHALL be high in the cycle after edge E32, and low in every other cycle.
REQ-021 busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
REQ-022 Any start pulse sampled in MULT or DIV SHALL be ignored; the in-flight operation and the operands it latched SHALL be unaffected.
REQ-023 Multiply: the operands SHALL be two's complement and data_result SHALL equal bits [31:0] of the exact 64-bit product.
REQ-024 Multiply: data_exception SHALL be 1 when the exact product is outside [-2^31, 2^31-1].
REQ-025 Divide: the quotient SHALL be signed and truncated toward zero; the remainder SHALL be discarded.
REQ-026 Divide by zero (B=0): data_result SHALL be 0x00000000 and data_exception SHALL be 1.
REQ-027 Divide 0x80000000 by 0xFFFFFFFF: data_result SHALL be 0x80000000 and data_exception SHALL be 1.
REQ-028 data_result and data_exception SHALL hold their DONE values until the next accepted start, and MAY change freely while busy=1.
REQ-029 Changes on data_operandA or data_operandB after the start edge SHALL NOT affect the result.

Reset
REQ-030 On an edge with reset=1, the FSM SHALL go to IDLE and the counter, data_result, data_exception, data_resultRDY and busy SHALL all become 0.
REQ-031 Reset SHALL take priority over simultaneous start pulses; a start pulse on the reset edge SHALL be discarded.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no data_resultRDY pulse.
REQ-033 The first start accepted after reset SHALL behave identically to one accepted from power-up.

Verification
REQ-034 The bench SHALL drive ctrl_MULT with A=7, B=0xFFFFFFFD (-3) at E0 -> busy=1 from E1 through E32; data_resultRDY=1 only after E32; data_result=0xFFFFFFEB; exception=0.
REQ-035 The bench SHALL drive ctrl_MULT with A=B=0x00010000 -> data_result=0x00000000 and data_exception=1 at ready.
REQ-036 The bench SHALL drive ctrl_DIV with A=0xFFFFFFEB (-21), B=4 -> data_result=0xFFFFFFFB (-5) and exception=0; it SHALL then drive ctrl_DIV with A=5, B=0 -> data_result=0 and exception=1.
REQ-037 The bench SHALL drive ctrl_MULT with A=3, B=5, then ctrl_DIV at E10 with different operands -> the second pulse is ignored; a single ready pulse after E32 with data_result=15.
REQ-038 The bench SHALL start a divide, assert reset at E15 -> busy=0 after E15 and no ready pulse; ctrl_MULT with A=B=2 at E20 -> data_result=4 after E52.
REQ-039 The bench SHALL apply back-to-back starts, pulsing ctrl_MULT in the DONE cycle -> the new operation is accepted, with its ready pulse 33 edges later.
